// File: rtl/rx_msg_receiver.sv
// TCPCI receive FSM: SOP* filtering, RX_BUF byte writes, GoodCRC request and ALERT/byte-count/frame-type reporting.
// Latency: every output is registered (1 cycle); no backpressure - PHY bytes are never stalled, overflow is flagged in ALERT.
module rx_msg_receiver #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 5,
  parameter int MAX_BYTES    = 30,
  parameter int GCRC_TIMEOUT = 16,
  parameter int ALERT_W      = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               Start,
  input  logic [2:0]         iSOP_TYPE,
  input  logic [7:0]         iRECEIVE_DETECT,
  input  logic [ALERT_W-1:0] iALERT,
  input  logic               Data_Valid,
  input  logic [DATA_W-1:0]  Data_In,
  input  logic               End,
  input  logic               CRC_Err,
  input  logic               Tx_State_Machine_ACTIVE,
  input  logic               Unexpected_GoodCRC,
  input  logic               CC_Busy,
  input  logic               CC_IDLE,
  output logic [ALERT_W-1:0] oALERT,
  output logic [7:0]         oRECEIVE_BYTE_COUNT,
  output logic [7:0]         oRX_BUF_FRAME_TYPE,
  output logic               oGoodCRC_to_PHY,
  output logic [ADDR_W-1:0]  oDIR_WRITE,
  output logic [DATA_W-1:0]  oDATA_to_Buffer,
  output logic               oWRITE_EN,
  output logic               oBusy
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(GCRC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BYTES);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(GCRC_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_RECEIVE    = 3'd1;
  localparam logic [2:0] S_DISCARD    = 3'd2;
  localparam logic [2:0] S_GOODCRC    = 3'd3;
  localparam logic [2:0] S_REPORT     = 3'd4;
  localparam logic [2:0] S_HARD_RESET = 3'd5;

  logic [2:0]         state, nxt_state;
  logic [CNT_W-1:0]   count, nxt_count;
  logic [2:0]         sop_type, nxt_type;
  logic [TMO_W-1:0]   tmo, nxt_tmo;
  logic               wr_en, gcrc, rpt;
  logic [ALERT_W-1:0] set_mask;
  logic               sop_en, start_live;

  assign sop_en     = iRECEIVE_DETECT[iSOP_TYPE] && (iSOP_TYPE != 3'd7);
  // Start restarts the decode from any state that can accept a new SOP; REPORT/HARD_RESET always finish first.
  assign start_live = Start && ((state == S_IDLE) || (state == S_RECEIVE) ||
                                (state == S_GOODCRC) || (state == S_DISCARD));

  always_comb begin
    nxt_state = state;
    nxt_count = count;
    nxt_type  = sop_type;
    nxt_tmo   = tmo;
    wr_en     = 1'b0;
    gcrc      = 1'b0;
    rpt       = 1'b0;
    set_mask  = '0;
    if (start_live) begin
      nxt_state = S_IDLE;
      if (sop_en) begin
        if (iSOP_TYPE == 3'd5) begin
          nxt_state = S_HARD_RESET;
        end else if (iALERT[2]) begin
          nxt_state   = S_DISCARD;
          set_mask[10] = 1'b1;
        end else begin
          nxt_state = S_RECEIVE;
          nxt_type  = iSOP_TYPE;
          nxt_count = '0;
        end
      end
    end else begin
      case (state)
        S_RECEIVE: begin
          if (Data_Valid && (count >= MAX_CNT)) begin
            set_mask[10] = 1'b1;
            nxt_state    = S_DISCARD;
          end else begin
            if (Data_Valid) begin
              wr_en     = 1'b1;
              nxt_count = count + 1'b1;
            end
            if (End) begin
              if (CRC_Err || (Unexpected_GoodCRC && !Tx_State_Machine_ACTIVE)) begin
                nxt_state = S_IDLE;
              end else begin
                nxt_state = S_GOODCRC;
                nxt_tmo   = TMO_LOAD;
              end
            end
          end
        end
        S_GOODCRC: begin
          if (CC_IDLE && !CC_Busy) begin
            gcrc      = 1'b1;
            nxt_state = S_REPORT;
          end else if (tmo <= TMO_ONE) begin
            nxt_tmo   = '0;
            nxt_state = S_IDLE;
          end else begin
            nxt_tmo = tmo - 1'b1;
          end
        end
        S_REPORT: begin
          rpt         = 1'b1;
          set_mask[2] = 1'b1;
          nxt_state   = S_IDLE;
        end
        S_HARD_RESET: begin
          set_mask[3] = 1'b1;
          nxt_count   = '0;
          nxt_state   = S_IDLE;
        end
        S_DISCARD: begin
          if (End) nxt_state = S_IDLE;
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      count               <= '0;
      sop_type            <= '0;
      tmo                 <= '0;
      oALERT              <= '0;
      oRECEIVE_BYTE_COUNT <= '0;
      oRX_BUF_FRAME_TYPE  <= '0;
      oGoodCRC_to_PHY     <= 1'b0;
      oDIR_WRITE          <= '0;
      oDATA_to_Buffer     <= '0;
      oWRITE_EN           <= 1'b0;
      oBusy               <= 1'b0;
    end else begin
      state           <= nxt_state;
      count           <= nxt_count;
      sop_type        <= nxt_type;
      tmo             <= nxt_tmo;
      oALERT          <= iALERT | set_mask;
      oGoodCRC_to_PHY <= gcrc;
      oWRITE_EN       <= wr_en;
      oBusy           <= (nxt_state != S_IDLE);
      if (wr_en) begin
        oDIR_WRITE      <= count[ADDR_W-1:0];
        oDATA_to_Buffer <= Data_In;
      end
      if (rpt) begin
        oRECEIVE_BYTE_COUNT <= 8'(count);
        oRX_BUF_FRAME_TYPE  <= {5'b0, sop_type};
      end
    end
  end

endmodule

// File: tb/tb_rx_msg_receiver.sv
// Directed bench for rx_msg_receiver: message sequences with hand-computed writes, pulses and report values.
module tb_rx_msg_receiver;

  logic        CLK = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  iSOP_TYPE;
  logic [7:0]  iRECEIVE_DETECT;
  logic [15:0] iALERT;
  logic        Data_Valid;
  logic [7:0]  Data_In;
  logic        End;
  logic        CRC_Err;
  logic        Tx_State_Machine_ACTIVE;
  logic        Unexpected_GoodCRC;
  logic        CC_Busy;
  logic        CC_IDLE;
  logic [15:0] oALERT;
  logic [7:0]  oRECEIVE_BYTE_COUNT;
  logic [7:0]  oRX_BUF_FRAME_TYPE;
  logic        oGoodCRC_to_PHY;
  logic [4:0]  oDIR_WRITE;
  logic [7:0]  oDATA_to_Buffer;
  logic        oWRITE_EN;
  logic        oBusy;

  always #5 CLK = ~CLK;

  rx_msg_receiver #(
    .DATA_W(8), .ADDR_W(5), .MAX_BYTES(30), .GCRC_TIMEOUT(16), .ALERT_W(16)
  ) dut (
    .CLK(CLK), .reset(reset), .Start(Start), .iSOP_TYPE(iSOP_TYPE),
    .iRECEIVE_DETECT(iRECEIVE_DETECT), .iALERT(iALERT),
    .Data_Valid(Data_Valid), .Data_In(Data_In), .End(End), .CRC_Err(CRC_Err),
    .Tx_State_Machine_ACTIVE(Tx_State_Machine_ACTIVE),
    .Unexpected_GoodCRC(Unexpected_GoodCRC), .CC_Busy(CC_Busy), .CC_IDLE(CC_IDLE),
    .oALERT(oALERT), .oRECEIVE_BYTE_COUNT(oRECEIVE_BYTE_COUNT),
    .oRX_BUF_FRAME_TYPE(oRX_BUF_FRAME_TYPE), .oGoodCRC_to_PHY(oGoodCRC_to_PHY),
    .oDIR_WRITE(oDIR_WRITE), .oDATA_to_Buffer(oDATA_to_Buffer),
    .oWRITE_EN(oWRITE_EN), .oBusy(oBusy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt, gcrc_cnt, a2_cnt, a3_cnt, a10_cnt, busy_cnt;
  logic [4:0] wr_addr [64];
  logic [7:0] wr_data [64];
  logic [7:0] msg [64];

  // Output monitor samples on the falling edge, mid-way between registered updates.
  always @(negedge CLK) begin
    if (oWRITE_EN) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = oDIR_WRITE;
        wr_data[wr_cnt] = oDATA_to_Buffer;
      end
      wr_cnt++;
    end
    if (oGoodCRC_to_PHY) gcrc_cnt++;
    if (oALERT[2])  a2_cnt++;
    if (oALERT[3])  a3_cnt++;
    if (oALERT[10]) a10_cnt++;
    if (oBusy)      busy_cnt++;
  end

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_mon;
    wr_cnt = 0; gcrc_cnt = 0; a2_cnt = 0; a3_cnt = 0; a10_cnt = 0; busy_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_msg(input logic [2:0] typ, input int n, input logic crc,
                          input logic ugc, input logic do_end, input int idle);
    Start = 1'b1; iSOP_TYPE = typ;
    tick;
    Start = 1'b0;
    for (int i = 0; i < n; i++) begin
      Data_Valid = 1'b1; Data_In = msg[i];
      tick;
    end
    Data_Valid = 1'b0;
    if (do_end) begin
      End = 1'b1; CRC_Err = crc; Unexpected_GoodCRC = ugc;
      tick;
      End = 1'b0; CRC_Err = 1'b0; Unexpected_GoodCRC = 1'b0;
    end
    repeat (idle) tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_bytes [4];
    exp_bytes[0] = 8'hA1; exp_bytes[1] = 8'hB2; exp_bytes[2] = 8'hC3; exp_bytes[3] = 8'hD4;

    reset = 1'b1; Start = 0; iSOP_TYPE = 0; iRECEIVE_DETECT = 8'h01; iALERT = 16'h0004;
    Data_Valid = 0; Data_In = 0; End = 0; CRC_Err = 0; Tx_State_Machine_ACTIVE = 0;
    Unexpected_GoodCRC = 0; CC_Busy = 0; CC_IDLE = 1;
    clear_mon;
    tick; tick;
    chk("rst_alert", oALERT, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_wr_en", oWRITE_EN, 0);
    chk("rst_gcrc", oGoodCRC_to_PHY, 0);
    chk("rst_count", oRECEIVE_BYTE_COUNT, 0);
    chk("rst_frame", oRX_BUF_FRAME_TYPE, 0);
    iALERT = 16'h0000; reset = 1'b0;
    tick;

    // Reset in the middle of a message
    Start = 1'b1; iSOP_TYPE = 3'd0; tick;
    Start = 1'b0; Data_Valid = 1'b1; Data_In = 8'h55; tick; tick;
    chk("mid_wr_en_pre", oWRITE_EN, 1);
    chk("mid_addr_pre", oDIR_WRITE, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", oWRITE_EN, 0);
    chk("mid_rst_busy", oBusy, 0);
    chk("mid_rst_addr", oDIR_WRITE, 0);
    Data_Valid = 1'b0;
    tick;
    reset = 1'b0;
    clear_mon;
    repeat (4) tick;
    chk("post_rst_writes", wr_cnt, 0);
    chk("post_rst_busy", oBusy, 0);

    // Basic SOP message, 4 bytes
    for (int i = 0; i < 4; i++) msg[i] = exp_bytes[i];
    clear_mon;
    send_msg(3'd0, 4, 1'b0, 1'b0, 1'b1, 5);
    chk("basic_writes", wr_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      chk("basic_addr", wr_addr[i], i);
      chk("basic_data", wr_data[i], exp_bytes[i]);
    end
    chk("basic_gcrc", gcrc_cnt, 1);
    chk("basic_alert2", a2_cnt, 1);
    chk("basic_alert10", a10_cnt, 0);
    chk("basic_busy_cycles", busy_cnt, 7);
    chk("basic_count", oRECEIVE_BYTE_COUNT, 4);
    chk("basic_frame", oRX_BUF_FRAME_TYPE, 0);

    // Disabled type is ignored
    clear_mon;
    send_msg(3'd1, 4, 1'b0, 1'b0, 1'b1, 5);
    chk("filt_writes", wr_cnt, 0);
    chk("filt_busy", busy_cnt, 0);

    // CRC error: bytes land in the buffer but nothing is reported
    clear_mon;
    send_msg(3'd0, 4, 1'b1, 1'b0, 1'b1, 5);
    chk("crc_writes", wr_cnt, 4);
    chk("crc_gcrc", gcrc_cnt, 0);
    chk("crc_alert2", a2_cnt, 0);
    chk("crc_count_held", oRECEIVE_BYTE_COUNT, 4);

    // Unexpected GoodCRC dropped unless the Tx machine waits for one
    msg[0] = 8'h11; msg[1] = 8'h22;
    clear_mon;
    send_msg(3'd0, 2, 1'b0, 1'b1, 1'b1, 5);
    chk("ugc_drop_gcrc", gcrc_cnt, 0);
    chk("ugc_drop_alert2", a2_cnt, 0);
    Tx_State_Machine_ACTIVE = 1'b1;
    clear_mon;
    send_msg(3'd0, 2, 1'b0, 1'b1, 1'b1, 5);
    chk("ugc_tx_gcrc", gcrc_cnt, 1);
    chk("ugc_tx_count", oRECEIVE_BYTE_COUNT, 2);
    Tx_State_Machine_ACTIVE = 1'b0;

    // Overflow: 31 bytes against a 30-byte limit
    for (int i = 0; i < 31; i++) msg[i] = 8'(i + 16);
    clear_mon;
    send_msg(3'd0, 31, 1'b0, 1'b0, 1'b1, 5);
    chk("ovf_writes", wr_cnt, 30);
    chk("ovf_last_addr", wr_addr[29], 29);
    chk("ovf_last_data", wr_data[29], 8'h2D);
    chk("ovf_alert10", a10_cnt, 1);
    chk("ovf_gcrc", gcrc_cnt, 0);
    chk("ovf_alert2", a2_cnt, 0);
    chk("ovf_count_held", oRECEIVE_BYTE_COUNT, 2);

    // Previous message unread
    iALERT = 16'h0004;
    clear_mon;
    send_msg(3'd0, 3, 1'b0, 1'b0, 1'b1, 5);
    chk("unread_writes", wr_cnt, 0);
    chk("unread_alert10", a10_cnt, 1);
    chk("unread_gcrc", gcrc_cnt, 0);
    iALERT = 16'h0000;

    // Hard Reset and Cable Reset
    iRECEIVE_DETECT = 8'h61;
    clear_mon;
    send_msg(3'd5, 0, 1'b0, 1'b0, 1'b1, 5);
    chk("hr_alert3", a3_cnt, 1);
    chk("hr_writes", wr_cnt, 0);
    chk("hr_busy_cycles", busy_cnt, 1);
    msg[0] = 8'h66; msg[1] = 8'h77;
    clear_mon;
    send_msg(3'd6, 2, 1'b0, 1'b0, 1'b1, 5);
    chk("cr_count", oRECEIVE_BYTE_COUNT, 2);
    chk("cr_frame", oRX_BUF_FRAME_TYPE, 6);
    chk("cr_gcrc", gcrc_cnt, 1);
    chk("cr_alert2", a2_cnt, 1);

    // Type 7 never accepted even with every enable set
    iRECEIVE_DETECT = 8'hFF;
    clear_mon;
    send_msg(3'd7, 2, 1'b0, 1'b0, 1'b1, 5);
    chk("t7_busy", busy_cnt, 0);
    chk("t7_writes", wr_cnt, 0);
    iRECEIVE_DETECT = 8'h01;

    // New Start mid-message restarts at address 0
    for (int i = 0; i < 3; i++) msg[i] = 8'(i + 1);
    clear_mon;
    send_msg(3'd0, 2, 1'b0, 1'b0, 1'b0, 0);
    send_msg(3'd0, 3, 1'b0, 1'b0, 1'b1, 5);
    chk("abort_writes", wr_cnt, 5);
    chk("abort_restart_addr", wr_addr[2], 0);
    chk("abort_last_addr", wr_addr[4], 2);
    chk("abort_gcrc", gcrc_cnt, 1);
    chk("abort_count", oRECEIVE_BYTE_COUNT, 3);

    // GoodCRC timeout with the bus held busy
    CC_Busy = 1'b1; CC_IDLE = 1'b0;
    clear_mon;
    send_msg(3'd0, 1, 1'b0, 1'b0, 1'b1, 20);
    chk("tmo_gcrc", gcrc_cnt, 0);
    chk("tmo_alert2", a2_cnt, 0);
    chk("tmo_busy_cycles", busy_cnt, 18);
    chk("tmo_idle", oBusy, 0);
    chk("tmo_count_held", oRECEIVE_BYTE_COUNT, 3);
    CC_Busy = 1'b0; CC_IDLE = 1'b1;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_msg_receiver.md
Name: rx_msg_receiver

Overview:
- Parametrised next-generation USB-PD (TCPCI) receive state machine, successor to the fixed 8-bit Rx block.
- Sits between the PHY byte stream and the RX_BUF register file. It performs:
  - per-SOP* filtering against RECEIVE_DETECT;
  - byte write into the receive buffer;
  - CRC-dependent GoodCRC request toward the PHY, with a bus-idle timeout;
  - overflow and hard-reset detection;
  - ALERT / RECEIVE_BYTE_COUNT / RX_BUF_FRAME_TYPE reporting.

Parameters:
- DATA_W, 8, width of Data_In and oDATA_to_Buffer.
- ADDR_W, 5, buffer address width.
- MAX_BYTES, 30, maximum accepted payload bytes per message. Must be ≤ 2^ADDR_W.
- GCRC_TIMEOUT, 16, cycles to wait for a free bus before the GoodCRC request is abandoned.
- ALERT_W, 16, ALERT register width.

Ports:
- CLK  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle SOP detected strobe from the PHY.
- iSOP_TYPE  in  3  SOP* type qualified by Start: 0 SOP, 1 SOP', 2 SOP'', 3 SOP'_Dbg, 4 SOP''_Dbg, 5 Hard Reset, 6 Cable Reset.
- iRECEIVE_DETECT  in  8  per-type enable bits; bit n enables type n.
- iALERT  in  ALERT_W  current ALERT register value.
- Data_Valid  in  1  Data_In qualifier.
- Data_In  in  DATA_W  received byte.
- End  in  1  EOP strobe.
- CRC_Err  in  1  CRC status, qualified by End.
- Tx_State_Machine_ACTIVE  in  1  Tx machine is awaiting a GoodCRC.
- Unexpected_GoodCRC  in  1  received message is a GoodCRC; qualified by End.
- CC_Busy  in  1  CC line busy.
- CC_IDLE  in  1  CC line idle.
- oALERT  out  ALERT_W  updated ALERT value.
- oRECEIVE_BYTE_COUNT  out  8  bytes of the last reported message.
- oRX_BUF_FRAME_TYPE  out  8  bits[2:0] hold the SOP type of the last reported message; upper bits are 0.
- oGoodCRC_to_PHY  out  1  one-cycle GoodCRC transmit request.
- oDIR_WRITE  out  ADDR_W  buffer write address.
- oDATA_to_Buffer  out  DATA_W  buffer write data.
- oWRITE_EN  out  1  buffer write strobe.
- oBusy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (async):
  - state goes to IDLE;
  - byte count and timeout counter are cleared;
  - all outputs are 0, including oALERT.
- All outputs are registered.
- oALERT:
  - each cycle, oALERT <= iALERT | set_mask;
  - set_mask is 0 except in the event cycles named below, where it carries the listed bit.
- States: IDLE, RECEIVE, DISCARD, GOODCRC, REPORT, HARD_RESET.
- IDLE, on Start:
  - type not enabled (iRECEIVE_DETECT[iSOP_TYPE]=0) or type 7: ignore, stay in IDLE.
  - type 5 enabled: go to HARD_RESET.
  - any other enabled type with iALERT[2]=1 (previous message unread): go to DISCARD and set ALERT bit 10 (Rx buffer overflow) for 1 cycle.
  - any other enabled type with iALERT[2]=0: go to RECEIVE, latch the SOP type, clear the count.
- RECEIVE:
  - Data_Valid with count<MAX_BYTES:
    - next cycle: oWRITE_EN=1, oDIR_WRITE=count, oDATA_to_Buffer=Data_In;
    - count increments.
  - Data_Valid with count==MAX_BYTES: no write, set ALERT bit 10, go to DISCARD.
  - Data_Valid and End in the same cycle: the byte is written first, then End is evaluated.
  - End with CRC_Err=1: drop silently, go to IDLE.
  - End with Unexpected_GoodCRC=1 and Tx_State_Machine_ACTIVE=0: drop silently, go to IDLE.
  - End otherwise: go to GOODCRC and load the timeout counter with GCRC_TIMEOUT.
- GOODCRC:
  - CC_IDLE=1 and CC_Busy=0: oGoodCRC_to_PHY=1 for one cycle, go to REPORT.
  - Otherwise the counter decrements; at 0, drop the message (no alert) and go to IDLE.
- REPORT (1 cycle):
  - oRECEIVE_BYTE_COUNT <= count (zero-extended);
  - oRX_BUF_FRAME_TYPE <= {5'b0, type};
  - set ALERT bit 2;
  - go to IDLE.
  - oRECEIVE_BYTE_COUNT and oRX_BUF_FRAME_TYPE hold until the next REPORT.
- DISCARD:
  - no writes; ignore Data_Valid;
  - leave to IDLE on End, or on Start (Start is re-evaluated as in IDLE in the same cycle).
- HARD_RESET (1 cycle):
  - set ALERT bit 3;
  - clear count;
  - go to IDLE.
- Start while in RECEIVE or GOODCRC:
  - abort the current message (no alert, no GoodCRC);
  - evaluate the new Start as in IDLE.
- Precedence:
  - reset beats everything;
  - Start beats End in the same cycle;
  - overflow beats End.
- Cable Reset (type 6) is handled as a normal message and reported with frame type 110b.

Test Plan:
- Reset asserted mid-RECEIVE -> all outputs 0 immediately; after release, oBusy=0 and no stale write occurs.
- RECEIVE_DETECT=0x01; SOP type 0; 4 bytes A1,B2,C3,D4; End, CRC ok; CC_IDLE=1 -> writes at addresses 0..3 with those bytes, one GoodCRC pulse, oRECEIVE_BYTE_COUNT=4, oRX_BUF_FRAME_TYPE=0, oALERT bit 2 set for one cycle.
- RECEIVE_DETECT=0x01; Start with type 1 -> no writes, oBusy stays 0. Same message with CRC_Err=1 -> no GoodCRC, no ALERT change.
- MAX_BYTES=30; 31 bytes sent -> exactly 30 writes, ALERT bit 10 set, no GoodCRC, oRECEIVE_BYTE_COUNT unchanged. Also: iALERT[2]=1 at Start -> bit 10 set and 0 writes.
- Type 5 with RECEIVE_DETECT[5]=1 -> ALERT bit 3 pulse, no writes. Type 6 message of 2 bytes -> reported with frame type 6 and count 2.
- CC_Busy=1 held for 20 cycles after a good End (GCRC_TIMEOUT=16) -> no GoodCRC, no ALERT bit 2, returns to IDLE after 16 cycles.
